// File: rtl/num_entry_buffer_pkg.sv
// Shared scancode constants, FSM encodings and MMIO offsets for the number entry buffer.
// The MMIO offsets are also consumed by mmio_controller.
package num_entry_buffer_pkg;
  localparam logic [7:0] SC_BREAK = 8'hF0;
  localparam logic [7:0] SC_EXT   = 8'hE0;
  localparam logic [7:0] SC_ENTER = 8'h5A;
  localparam logic [7:0] SC_BKSP  = 8'h66;
  localparam logic [7:0] SC_ESC   = 8'h76;

  localparam logic [31:0] MMIO_NUM_BUFFER = 32'h5000_0000;
  localparam logic [31:0] MMIO_NUM_VALID  = 32'h5000_0004;

  typedef enum logic {S_IDLE = 1'b0, S_CONV = 1'b1} state_t;
endpackage

// File: rtl/num_entry_buffer_ps2_digit_decode.sv
// Set-2 make code to decimal digit lookup (combinational).
// NUM_BUF_KEYPAD_EN adds the numeric keypad digit codes.
module ps2_digit_decode (
  input  logic [7:0] code,
  input  logic       ext,
  output logic       is_digit,
  output logic [3:0] digit
);
  always_comb begin
    is_digit = 1'b0;
    digit    = 4'd0;
    if (!ext) begin
      is_digit = 1'b1;
      case (code)
        8'h45: digit = 4'd0;
        8'h16: digit = 4'd1;
        8'h1E: digit = 4'd2;
        8'h26: digit = 4'd3;
        8'h25: digit = 4'd4;
        8'h2E: digit = 4'd5;
        8'h36: digit = 4'd6;
        8'h3D: digit = 4'd7;
        8'h3E: digit = 4'd8;
        8'h46: digit = 4'd9;
`ifdef NUM_BUF_KEYPAD_EN
        8'h70: digit = 4'd0;
        8'h69: digit = 4'd1;
        8'h72: digit = 4'd2;
        8'h7A: digit = 4'd3;
        8'h6B: digit = 4'd4;
        8'h73: digit = 4'd5;
        8'h74: digit = 4'd6;
        8'h6C: digit = 4'd7;
        8'h75: digit = 4'd8;
        8'h7D: digit = 4'd9;
`endif
        default: is_digit = 1'b0;
      endcase
    end
  end
endmodule

// File: rtl/num_entry_buffer.sv
// Keyboard number entry: BCD digit collection with editing, multi-cycle BCD->binary on Enter.
// Optional macro NUM_BUF_KEYPAD_EN accepts keypad digits and E0-prefixed keypad Enter.
module num_entry_buffer
  import num_entry_buffer_pkg::*;
#(
  parameter int MAX_DIGITS = 9,
  parameter int CNT_W      = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [7:0]       ps2_code,
  input  logic             ps2_code_valid,
  input  logic             num_ack,
  output logic [31:0]      num_buffer,
  output logic             num_valid,
  output logic             busy,
  output logic [CNT_W-1:0] digit_count,
  output logic             drop_flag
);
  state_t                          state_q, state_d;
  logic                            brk_q, brk_d, ext_q, ext_d;
  logic [MAX_DIGITS-1:0][3:0]      bcd_q, bcd_d;
  logic [CNT_W-1:0]                cnt_q, cnt_d, idx_q, idx_d;
  logic [31:0]                     acc_q, acc_d, acc_nxt, num_q, num_d;
  logic                            valid_q, valid_d, drop_q, drop_d, drop_set;
  logic                            is_digit, is_enter, is_bksp, is_esc, valid_eff;
  logic [3:0]                      dig, cur_dig;

  ps2_digit_decode u_dec (
    .code     (ps2_code),
    .ext      (ext_q),
    .is_digit (is_digit),
    .digit    (dig)
  );

`ifdef NUM_BUF_KEYPAD_EN
  assign is_enter = (ps2_code == SC_ENTER);
`else
  assign is_enter = (ps2_code == SC_ENTER) && !ext_q;
`endif
  assign is_bksp   = (ps2_code == SC_BKSP) && !ext_q;
  assign is_esc    = (ps2_code == SC_ESC)  && !ext_q;
  // A same-cycle ack frees the buffer for the byte arriving with it.
  assign valid_eff = valid_q && !num_ack;
  assign cur_dig   = bcd_q[idx_q];
  assign acc_nxt   = (acc_q << 3) + (acc_q << 1) + {28'd0, cur_dig};

  always_comb begin
    state_d  = state_q;
    brk_d    = brk_q;
    ext_d    = ext_q;
    bcd_d    = bcd_q;
    cnt_d    = cnt_q;
    idx_d    = idx_q;
    acc_d    = acc_q;
    num_d    = num_q;
    valid_d  = valid_eff;
    drop_set = 1'b0;
    if (ps2_code_valid) begin
      if (ps2_code == SC_BREAK) begin
        brk_d = 1'b1;
      end else if (ps2_code == SC_EXT) begin
        ext_d = 1'b1;
      end else begin
        brk_d = 1'b0;
        ext_d = 1'b0;
        if (!brk_q) begin
          if (state_q == S_IDLE && !valid_eff) begin
            if (is_digit) begin
              if (cnt_q == CNT_W'(MAX_DIGITS)) begin
                drop_set = 1'b1;
              end else begin
                bcd_d = {bcd_q[MAX_DIGITS-2:0], dig};
                cnt_d = cnt_q + 1'b1;
              end
            end else if (is_enter) begin
              if (cnt_q != '0) begin
                state_d = S_CONV;
                acc_d   = '0;
                idx_d   = cnt_q - 1'b1;
              end
            end else if (is_bksp) begin
              if (cnt_q != '0) begin
                bcd_d = {4'd0, bcd_q[MAX_DIGITS-1:1]};
                cnt_d = cnt_q - 1'b1;
              end
            end else if (is_esc) begin
              bcd_d = '0;
              cnt_d = '0;
            end
          end else if (is_digit) begin
            drop_set = 1'b1;
          end
        end
      end
    end
    // Most significant digit sits at nibble cnt-1; walk down to nibble 0.
    if (state_q == S_CONV) begin
      acc_d = acc_nxt;
      idx_d = idx_q - 1'b1;
      if (idx_q == '0) begin
        num_d   = acc_nxt;
        valid_d = 1'b1;
        bcd_d   = '0;
        cnt_d   = '0;
        state_d = S_IDLE;
      end
    end
    drop_d = (drop_q && !num_ack) || drop_set;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      brk_q   <= 1'b0;
      ext_q   <= 1'b0;
      bcd_q   <= '0;
      cnt_q   <= '0;
      idx_q   <= '0;
      acc_q   <= '0;
      num_q   <= '0;
      valid_q <= 1'b0;
      drop_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      brk_q   <= brk_d;
      ext_q   <= ext_d;
      bcd_q   <= bcd_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      acc_q   <= acc_d;
      num_q   <= num_d;
      valid_q <= valid_d;
      drop_q  <= drop_d;
    end
  end

  assign num_buffer  = num_q;
  assign num_valid   = valid_q;
  assign busy        = (state_q == S_CONV);
  assign digit_count = cnt_q;
  assign drop_flag   = drop_q;
endmodule

// File: tb/tb_num_entry_buffer.sv
// Directed bench for num_entry_buffer: entry, editing, conversion latency, ack and reset.
module tb_num_entry_buffer;
  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [7:0]  ps2_code = 8'h00;
  logic        ps2_code_valid = 1'b0;
  logic        num_ack = 1'b0;
  logic [31:0] num_buffer;
  logic        num_valid, busy, drop_flag;
  logic [3:0]  digit_count;
  int          total = 0;
  int          bad = 0;

  num_entry_buffer #(.MAX_DIGITS(9), .CNT_W(4)) dut (
    .clk            (clk),
    .rst            (rst),
    .ps2_code       (ps2_code),
    .ps2_code_valid (ps2_code_valid),
    .num_ack        (num_ack),
    .num_buffer     (num_buffer),
    .num_valid      (num_valid),
    .busy           (busy),
    .digit_count    (digit_count),
    .drop_flag      (drop_flag)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic send(input logic [7:0] c);
    @(negedge clk);
    ps2_code = c;
    ps2_code_valid = 1'b1;
    @(negedge clk);
    ps2_code_valid = 1'b0;
  endtask

  task automatic ack();
    @(negedge clk);
    num_ack = 1'b1;
    @(negedge clk);
    num_ack = 1'b0;
  endtask

  initial begin
    repeat (2) @(negedge clk);
    check("rst_buf", num_buffer, 0);
    check("rst_valid", {31'd0, num_valid}, 0);
    check("rst_busy", {31'd0, busy}, 0);
    check("rst_cnt", {28'd0, digit_count}, 0);
    check("rst_drop", {31'd0, drop_flag}, 0);
    rst = 1'b1;

    // 1: make/break sequence for 1,2,3 then Enter; exact 3-cycle latency
    send(8'h16); send(8'hF0); send(8'h16);
    send(8'h1E); send(8'hF0); send(8'h1E);
    send(8'h26); send(8'hF0); send(8'h26);
    check("t1_cnt", {28'd0, digit_count}, 3);
    send(8'h5A);
    check("t1_busy0", {31'd0, busy}, 1);
    @(negedge clk);
    check("t1_busy1", {31'd0, busy}, 1);
    check("t1_nv1", {31'd0, num_valid}, 0);
    @(negedge clk);
    check("t1_busy2", {31'd0, busy}, 1);
    check("t1_nv2", {31'd0, num_valid}, 0);
    @(negedge clk);
    check("t1_nv3", {31'd0, num_valid}, 1);
    check("t1_busy3", {31'd0, busy}, 0);
    check("t1_buf", num_buffer, 123);
    check("t1_cnt0", {28'd0, digit_count}, 0);
    send(8'hF0); send(8'h5A);
    check("t1_brk_idle", {31'd0, busy}, 0);
    ack();
    check("t1_ack", {31'd0, num_valid}, 0);
    check("t1_hold", num_buffer, 123);

    // 2: nine 9s, a tenth digit dropped, then convert
    repeat (9) send(8'h46);
    check("t2_cnt9", {28'd0, digit_count}, 9);
    send(8'h16);
    check("t2_cnt_full", {28'd0, digit_count}, 9);
    check("t2_drop", {31'd0, drop_flag}, 1);
    send(8'h5A);
    repeat (8) @(negedge clk);
    check("t2_busy_last", {31'd0, busy}, 1);
    @(negedge clk);
    check("t2_nv", {31'd0, num_valid}, 1);
    check("t2_buf", num_buffer, 999999999);
    check("t2_drop_hold", {31'd0, drop_flag}, 1);
    ack();
    check("t2_ack_nv", {31'd0, num_valid}, 0);
    check("t2_ack_drop", {31'd0, drop_flag}, 0);

    // 3: 4,5,Bksp,7 -> 47; then 8,8,Esc,Enter does nothing
    send(8'h25); send(8'h2E); send(8'h66);
    check("t3_bksp", {28'd0, digit_count}, 1);
    send(8'h3D);
    send(8'h5A);
    repeat (2) @(negedge clk);
    check("t3_nv", {31'd0, num_valid}, 1);
    check("t3_buf", num_buffer, 47);
    ack();
    send(8'h3E); send(8'h3E); send(8'h76);
    check("t3_esc", {28'd0, digit_count}, 0);
    send(8'h5A);
    check("t3_enter_busy", {31'd0, busy}, 0);
    repeat (3) @(negedge clk);
    check("t3_enter_nv", {31'd0, num_valid}, 0);
    send(8'h66);
    check("t3_bksp_at0", {28'd0, digit_count}, 0);

    // 4: Enter alone; digit while num_valid=1 is dropped
    send(8'h5A);
    check("t4_busy", {31'd0, busy}, 0);
    send(8'h2E); send(8'h5A);
    @(negedge clk);
    check("t4_buf", num_buffer, 5);
    send(8'h26);
    check("t4_drop", {31'd0, drop_flag}, 1);
    check("t4_cnt", {28'd0, digit_count}, 0);

    // 5: ack and digit 2 in the same cycle; then reset mid-conversion
    @(negedge clk);
    num_ack = 1'b1;
    ps2_code = 8'h1E;
    ps2_code_valid = 1'b1;
    @(negedge clk);
    num_ack = 1'b0;
    ps2_code_valid = 1'b0;
    check("t5_nv", {31'd0, num_valid}, 0);
    check("t5_cnt", {28'd0, digit_count}, 1);
    check("t5_drop", {31'd0, drop_flag}, 0);
    send(8'h26); send(8'h25); send(8'h5A);
    check("t5_busy", {31'd0, busy}, 1);
    #2 rst = 1'b0;
    #1;
    check("t5_rst_busy", {31'd0, busy}, 0);
    check("t5_rst_cnt", {28'd0, digit_count}, 0);
    check("t5_rst_buf", num_buffer, 0);
    check("t5_rst_nv", {31'd0, num_valid}, 0);
    @(negedge clk);
    rst = 1'b1;
    repeat (4) @(negedge clk);
    check("t5_post_nv", {31'd0, num_valid}, 0);

    // 6: keypad digits with E0-prefixed Enter
    send(8'h69); send(8'h72); send(8'hE0); send(8'h5A);
    repeat (3) @(negedge clk);
`ifdef NUM_BUF_KEYPAD_EN
    check("t6_kp_nv", {31'd0, num_valid}, 1);
    check("t6_kp_buf", num_buffer, 12);
`else
    check("t6_cnt", {28'd0, digit_count}, 0);
    check("t6_nv", {31'd0, num_valid}, 0);
    check("t6_busy", {31'd0, busy}, 0);
`endif
    ack();
    // E0-prefixed digit code is an extended key, never a digit
    send(8'hE0); send(8'h16);
    check("t6_ext_digit", {28'd0, digit_count}, 0);
    send(8'h16);
    check("t6_ext_clear", {28'd0, digit_count}, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/num_entry_buffer.md
Name: num_entry_buffer

Overview:
- Producer of the Number Input Buffer MMIO registers: at 0x50000000 (num_buffer) and 0x50000004 (num_valid).
- Consumes byte strobes from the PS2 receiver and decodes set-2 make/break codes.
- Collects decimal digits as BCD and supports Backspace/Esc editing.
- On Enter, converts the BCD digits to binary over several cycles and holds num_valid until the CPU acknowledges through the MMIO write path.

Parameters:
- MAX_DIGITS, 9: maximum number of BCD digits held (9 keeps 999,999,999 below 2^32); further digits are dropped.
- CNT_W, 4: width of digit_count; must satisfy 2^CNT_W > MAX_DIGITS.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-low reset
- ps2_code  in  8  raw scancode byte from the PS2 receiver
- ps2_code_valid  in  1  one-cycle strobe; ps2_code is valid in that cycle
- num_ack  in  1  one-cycle pulse, generated when the CPU does sw to 0x50000004; consumes the number
- num_buffer  out  32  committed binary value
- num_valid  out  1  committed value available
- busy  out  1  high while in S_CONV
- digit_count  out  CNT_W  number of digits currently being entered (for echo)
- drop_flag  out  1  sticky: a digit was dropped because the buffer was full or num_valid=1; cleared by num_ack

Behaviour:
- Reset (async, rst=0): num_buffer=0, num_valid=0, busy=0, digit_count=0, drop_flag=0, BCD buffer=0, FSM=S_IDLE, prefix flags cleared.
- Prefix tracking is active in every state:
  - 0xF0 sets brk. The next non-prefix byte is discarded and clears brk.
  - 0xE0 sets ext. The next non-prefix byte is decoded as extended and clears ext.
  - Extended codes are ignored unless the optional feature below is enabled.
- Make-code decode, active in S_IDLE with num_valid=0:
  - Digits: 45=0, 16=1, 1E=2, 26=3, 25=4, 2E=5, 36=6, 3D=7, 3E=8, 46=9. Each digit shifts left into the BCD buffer and increments digit_count.
  - Backspace (66): shifts the buffer right and decrements digit_count; no effect at 0.
  - Esc (76): clears the buffer; digit_count=0.
  - Enter (5A) with digit_count>0: go to S_CONV. Enter with digit_count=0 is ignored.
  - All other codes are ignored.
- Digit when full: a digit with digit_count==MAX_DIGITS is dropped and sets drop_flag.
- While num_valid=1: digits are dropped and set drop_flag; Enter, Backspace and Esc are ignored.
- S_CONV:
  - The accumulator is cleared on entry.
  - Each cycle processes one digit, MS first: acc = (acc<<3)+(acc<<1)+d, 32-bit arithmetic.
  - Exactly digit_count cycles; busy=1 throughout.
  - On the edge that processes the last digit: num_buffer<=acc_next, num_valid<=1, BCD buffer and digit_count<=0, go to S_IDLE.
  - Latency: Enter strobe at edge E0 → num_valid=1 after edge E(digit_count).
- Bytes arriving during S_CONV: prefix tracking still runs; digit, Enter and edit codes are discarded; digits set drop_flag.
- num_ack: clears num_valid and drop_flag on the next edge; num_buffer holds its value.
  - ack with num_valid=0 only clears drop_flag.
  - ack and a byte strobe in the same cycle: both take effect, and the byte is decoded as if num_valid were already 0.
  - ack during S_CONV: clears drop_flag only; the conversion completes normally.
- Reset mid-conversion aborts immediately to the reset values.

Optional Feature:
- Macro: NUM_BUF_KEYPAD_EN.
- Defined:
  - Keypad digits are also accepted: 70=0, 69=1, 72=2, 7A=3, 6B=4, 73=5, 74=6, 6C=7, 75=8, 7D=9.
  - E0-prefixed 5A (keypad Enter) acts as Enter.
- Undefined: those codes and all extended codes are ignored; no extra logic.

Decomposition:
- Shared header num_buf_defs.vh holds:
  - scancode constants: SC_BREAK, SC_EXT, SC_ENTER, SC_BKSP, SC_ESC;
  - FSM state encodings S_IDLE and S_CONV;
  - the MMIO offsets for num_buffer and num_valid, also used by mmio_controller.
- One natural sub-module: ps2_digit_decode, combinational. Maps scancode + ext to {is_digit, digit[3:0]}; the keypad table lives inside it under the macro.

Test Plan:
1. Bytes 16,F0,16,1E,F0,1E,26,F0,26,5A,F0,5A → num_valid=1 exactly 3 edges after the 5A strobe; num_buffer=123; busy high 3 cycles.
2. Digits 9,9,9,9,9,9,9,9,9 then 1, then Enter → num_buffer=999999999; drop_flag=1; num_ack → num_valid=0 and drop_flag=0 next edge.
3. Digits 4,5, Backspace, 7, Enter → num_buffer=47. Esc after 8,8 followed by Enter → num_valid stays 0.
4. Enter alone → no S_CONV, busy=0. With num_valid=1, digit 3 → drop_flag=1 and digit_count stays 0.
5. num_ack and digit 2 strobe in the same cycle while num_valid=1 → num_valid=0, digit_count=1. rst low during S_CONV → all outputs 0 asynchronously.
6. With NUM_BUF_KEYPAD_EN: 69,72,E0,5A → num_buffer=12. Without it: same bytes → digit_count=0, num_valid=0.
